imem_boot_loader: RTL and testbench

Boot-load sequencer between the UART receiver, instruction memory write port and CPU clock gate. It parses a framed byte stream (magic, length, payload, checksum) and assembles little-endian 32-bit words. It issues one imem write per word and holds the CPU stopped until a complete, checksum-verified image is in memory. It runs on the fast board clock, not on the divided CPU clock.

---
 rtl/imem_boot_loader_if.sv | 23 ++
 rtl/imem_boot_loader.sv | 137 +++++++++++++
 tb/tb_imem_boot_loader.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_if.sv
// Boot-loader bus: UART byte input, imem write port and CPU/status outputs.
interface imem_boot_loader_if;
   logic        enable;
   logic        uart_v;
   logic [7:0]  uart_d;
   logic        we;
   logic [31:0] wa;
   logic [31:0] wd;
   logic        cpu_hold;
   logic        busy;
   logic        done;
   logic [1:0]  err_code;

   modport master (
      output enable, uart_v, uart_d,
      input  we, wa, wd, cpu_hold, busy, done, err_code
   );

   modport slave (
      input  enable, uart_v, uart_d,
      output we, wa, wd, cpu_hold, busy, done, err_code
   );
endinterface

// File: rtl/imem_boot_loader.sv
// Framed UART boot loader: parses magic/len/payload/csum, writes LE words to imem, gates CPU.
// All outputs registered; we fires the cycle after a word's 4th byte. No backpressure: bytes are never stalled.
module imem_boot_loader #(
   parameter logic [7:0] MAGIC     = 8'hA5,
   parameter int         MAX_WORDS = 256,
   parameter int         TIMEOUT   = 1_000_000,
   parameter int         CNT_W     = 20
) (
   input  logic              clk,
   input  logic              rstn,
   imem_boot_loader_if.slave bus
);
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] SYNC   = 3'd1;
   localparam logic [2:0] LEN_LO = 3'd2;
   localparam logic [2:0] LEN_HI = 3'd3;
   localparam logic [2:0] DATA   = 3'd4;
   localparam logic [2:0] CSUM   = 3'd5;
   localparam logic [2:0] DONE   = 3'd6;
   localparam logic [2:0] ERROR  = 3'd7;

   localparam logic [16:0]      MAX_W   = 17'(MAX_WORDS);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

   logic [2:0]       state, state_n;
   logic [1:0]       err_n;
   logic             done_n;
   logic             busy_n;
   logic             hold_n;
   logic [15:0]      len;
   logic [15:0]      len_full;
   logic [1:0]       byte_cnt;
   logic [7:0]       csum;
   logic [CNT_W-1:0] tcnt;
   logic             in_frame;
   logic             active;
   logic             last_word;

   assign in_frame  = (state >= LEN_LO) && (state <= CSUM);
   assign active    = (state >= SYNC) && (state <= CSUM);
   assign last_word = (bus.wa == ({16'd0, len} - 32'd1));

   always_comb begin
      state_n  = state;
      err_n    = bus.err_code;
      done_n   = bus.done;
      len_full = {bus.uart_d, len[7:0]};
      case (state)
         IDLE: if (bus.enable) begin
            state_n = SYNC;
            err_n   = 2'd0;
            done_n  = 1'b0;
         end
         SYNC:   if (bus.uart_v && bus.uart_d == MAGIC) state_n = LEN_LO;
         LEN_LO: if (bus.uart_v) state_n = LEN_HI;
         LEN_HI: if (bus.uart_v) begin
            if (len_full == 16'd0 || {1'b0, len_full} > MAX_W) begin
               state_n = ERROR;
               err_n   = 2'd1;
            end else begin
               state_n = DATA;
            end
         end
         DATA: if (bus.uart_v && byte_cnt == 2'd3 && last_word) state_n = CSUM;
         CSUM: if (bus.uart_v) begin
            if (bus.uart_d == csum) begin
               state_n = DONE;
               done_n  = 1'b1;
            end else begin
               state_n = ERROR;
               err_n   = 2'd2;
            end
         end
         DONE, ERROR: if (!bus.enable) state_n = IDLE;
         default: state_n = IDLE;
      endcase
      // A byte arriving on the expiry cycle wins over the timeout; abort overrides everything.
      if (in_frame && !bus.uart_v && tcnt == TO_LAST) begin
         state_n = ERROR;
         err_n   = 2'd3;
      end
      if (active && !bus.enable) begin
         state_n = ERROR;
         err_n   = 2'd3;
      end
   end

   assign busy_n = (state_n >= SYNC) && (state_n <= CSUM);
   // After any error the CPU stays held until a later load succeeds.
   assign hold_n = (state_n == IDLE) ? (err_n != 2'd0) : (state_n != DONE);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= IDLE;
         bus.we       <= 1'b0;
         bus.wa       <= 32'd0;
         bus.wd       <= 32'd0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.err_code <= 2'd0;
         bus.cpu_hold <= 1'b0;
         len          <= 16'd0;
         byte_cnt     <= 2'd0;
         csum         <= 8'd0;
         tcnt         <= '0;
      end else begin
         state        <= state_n;
         bus.err_code <= err_n;
         bus.done     <= done_n;
         bus.busy     <= busy_n;
         bus.cpu_hold <= hold_n;
         bus.we       <= 1'b0;
         if (bus.we) bus.wa <= bus.wa + 32'd1;
         tcnt <= (in_frame && !bus.uart_v) ? tcnt + CNT_W'(1) : '0;
         if (state == IDLE && bus.enable) begin
            bus.wa   <= 32'd0;
            csum     <= 8'd0;
            byte_cnt <= 2'd0;
            len      <= 16'd0;
         end
         if (bus.uart_v && bus.enable) begin
            case (state)
               LEN_LO: len[7:0]  <= bus.uart_d;
               LEN_HI: len[15:8] <= bus.uart_d;
               DATA: begin
                  // Shift in from the top so byte 0 ends up in wd[7:0].
                  bus.wd   <= {bus.uart_d, bus.wd[31:8]};
                  csum     <= csum + bus.uart_d;
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) bus.we <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader with TIMEOUT=100 and a write-capture monitor.
module tb_imem_boot_loader;
   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   we_total = 0;
   int   base;
   logic [31:0] cap_wa [32];
   logic [31:0] cap_wd [32];

   imem_boot_loader_if bus ();

   imem_boot_loader #(.MAGIC(8'hA5), .MAX_WORDS(256), .TIMEOUT(100), .CNT_W(20)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.we) begin
         cap_wa[we_total[4:0]] <= bus.wa;
         cap_wd[we_total[4:0]] <= bus.wd;
         we_total <= we_total + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one byte for one cycle, then leave one idle cycle.
   task automatic send_byte(input logic [7:0] b);
      bus.uart_v = 1'b1;
      bus.uart_d = b;
      @(negedge clk);
      bus.uart_v = 1'b0;
      bus.uart_d = 8'h00;
      @(negedge clk);
   endtask

   task automatic restart();
      bus.enable = 1'b0;
      repeat (2) @(negedge clk);
      bus.enable = 1'b1;
      @(negedge clk);
   endtask

   // Two words 00000013, 00100093; 13+93+10 = B6.
   task automatic send_two_words(input logic [7:0] ck);
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
      send_byte(ck);
   endtask

   initial begin
      bus.enable = 1'b0;
      bus.uart_v = 1'b0;
      bus.uart_d = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_we", {31'd0, bus.we}, 32'd0);
      chk("rst_wa", bus.wa, 32'd0);
      chk("rst_wd", bus.wd, 32'd0);
      chk("rst_flags", {28'd0, bus.busy, bus.done, bus.cpu_hold, 1'b0}, 32'd0);
      chk("rst_err", {30'd0, bus.err_code}, 32'd0);
      rstn = 1'b1;
      @(negedge clk);

      // Good frame
      bus.enable = 1'b1;
      @(negedge clk);
      chk("sync_busy", {31'd0, bus.busy}, 32'd1);
      chk("sync_hold", {31'd0, bus.cpu_hold}, 32'd1);
      base = we_total;
      send_two_words(8'hB6);
      chk("good_we_cnt", we_total - base, 32'd2);
      chk("good_wa0", cap_wa[base], 32'd0);
      chk("good_wd0", cap_wd[base], 32'h0000_0013);
      chk("good_wa1", cap_wa[base + 1], 32'd1);
      chk("good_wd1", cap_wd[base + 1], 32'h0010_0093);
      chk("good_done", {31'd0, bus.done}, 32'd1);
      chk("good_err", {30'd0, bus.err_code}, 32'd0);
      chk("good_hold", {31'd0, bus.cpu_hold}, 32'd0);
      chk("good_busy", {31'd0, bus.busy}, 32'd0);
      repeat (4) @(negedge clk);
      chk("enable_held_no_restart", {31'd0, bus.busy}, 32'd0);
      bus.enable = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_done_sticky", {31'd0, bus.done}, 32'd1);

      // Bad checksum
      bus.enable = 1'b1;
      @(negedge clk);
      chk("restart_clears_done", {31'd0, bus.done}, 32'd0);
      base = we_total;
      send_two_words(8'hB7);
      chk("bad_we_cnt", we_total - base, 32'd2);
      chk("bad_err", {30'd0, bus.err_code}, 32'd2);
      chk("bad_hold", {31'd0, bus.cpu_hold}, 32'd1);
      bus.enable = 1'b0;
      repeat (3) @(negedge clk);
      chk("bad_idle_hold", {31'd0, bus.cpu_hold}, 32'd1);
      chk("bad_idle_err", {30'd0, bus.err_code}, 32'd2);

      // Length zero, then length 257
      bus.enable = 1'b1;
      @(negedge clk);
      base = we_total;
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
      chk("len0_err", {30'd0, bus.err_code}, 32'd1);
      restart();
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
      chk("len257_err", {30'd0, bus.err_code}, 32'd1);
      chk("len_no_we", we_total - base, 32'd0);

      // Sync noise; EF+BE+AD+DE = 0x338 -> 0x38
      restart();
      base = we_total;
      send_byte(8'hFF); send_byte(8'h00);
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
      send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
      send_byte(8'h38);
      chk("noise_we_cnt", we_total - base, 32'd1);
      chk("noise_wa0", cap_wa[base], 32'd0);
      chk("noise_wd0", cap_wd[base], 32'hDEAD_BEEF);
      chk("noise_done", {31'd0, bus.done}, 32'd1);
      chk("noise_hold", {31'd0, bus.cpu_hold}, 32'd0);

      // Timeout: last byte sampled one edge before send_byte returns
      restart();
      base = we_total;
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h13); send_byte(8'h00);
      repeat (98) @(negedge clk);
      chk("to_cycle99_err", {30'd0, bus.err_code}, 32'd0);
      chk("to_cycle99_busy", {31'd0, bus.busy}, 32'd1);
      @(negedge clk);
      chk("to_cycle100_err", {30'd0, bus.err_code}, 32'd3);
      chk("to_no_we", we_total - base, 32'd0);

      // Abort mid-DATA
      restart();
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h11);
      bus.enable = 1'b0;
      @(negedge clk);
      chk("abort_err", {30'd0, bus.err_code}, 32'd3);
      chk("abort_hold", {31'd0, bus.cpu_hold}, 32'd1);

      // Reset mid-frame, then a fresh good load
      bus.enable = 1'b1;
      repeat (2) @(negedge clk);
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h11); send_byte(8'h22);
      rstn = 1'b0;
      bus.enable = 1'b0;
      #1;
      chk("mid_rst_wd", bus.wd, 32'd0);
      chk("mid_rst_flags", {28'd0, bus.we, bus.busy, bus.done, bus.cpu_hold}, 32'd0);
      chk("mid_rst_err", {30'd0, bus.err_code}, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      bus.enable = 1'b1;
      @(negedge clk);
      base = we_total;
      send_two_words(8'hB6);
      chk("post_rst_we_cnt", we_total - base, 32'd2);
      chk("post_rst_wa0", cap_wa[base], 32'd0);
      chk("post_rst_wd1", cap_wd[base + 1], 32'h0010_0093);
      chk("post_rst_done", {31'd0, bus.done}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end
endmodule
